sram_arb_responder: RTL

SRAM_ARB_RESPONDER -- requirements
Module: sram_arb_responder

---
 rtl/sram_arb_responder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sram_arb_responder.sv
// sram_arb_responder
//   Accepts one arbiter request at a time and turns it into a single-cycle
//   SRAM access. Each accept is followed by a one-cycle gap, so accepts are
//   at least three cycles apart. Read IDs travel down a shift pipeline that
//   matches the SRAM read latency, and each read's data is returned with
//   its ID.
//
// Ports
//   clkSYS, n_reset            clock; synchronous active-low reset
//   mem_req/addr/data/id/wr    request from the arbiter
//   mem_ack                    one-cycle accept pulse
//   rsp_valid/rsp_id/rsp_mem   registered read response (id and data hold)
//   sram_wait                  SRAM busy; blocks new accepts
//   sram_ce/we/addr/wdata      SRAM access strobe, write enable, address, data
//   sram_rdata                 SRAM read data, valid RL cycles after sram_ce
module sram_arb_responder #(
  parameter int unsigned AN = 19,
  parameter int unsigned DN = 16,
  parameter int unsigned N  = 2,
  parameter int unsigned RL = 2
) (
  input  logic          clkSYS,
  input  logic          n_reset,
  input  logic          mem_req,
  input  logic [AN-1:0] mem_addr,
  input  logic [DN-1:0] mem_data,
  input  logic [N-1:0]  mem_id,
  input  logic          mem_wr,
  output logic          mem_ack,
  output logic          rsp_valid,
  output logic [N-1:0]  rsp_id,
  output logic [DN-1:0] rsp_mem,
  input  logic          sram_wait,
  output logic          sram_ce,
  output logic          sram_we,
  output logic [AN-1:0] sram_addr,
  output logic [DN-1:0] sram_wdata,
  input  logic [DN-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          wr_q, wr_d;
  logic [N-1:0]  id_q, id_d;
  logic [AN-1:0] addr_q, addr_d;
  logic [DN-1:0] wdata_q, wdata_d;
  logic [RL-1:0] pipe_v_q, pipe_v_d;
  logic [N-1:0]  pipe_id_q [RL];
  logic [N-1:0]  pipe_id_d [RL];
  logic          rsp_valid_q, rsp_valid_d;
  logic [N-1:0]  rsp_id_q, rsp_id_d;
  logic [DN-1:0] rsp_mem_q, rsp_mem_d;

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    id_d        = id_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pipe_v_d    = pipe_v_q;
    pipe_id_d   = pipe_id_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_mem_d   = rsp_mem_q;

    unique case (state_q)
      IDLE: begin
        if (mem_req && !sram_wait) begin
          state_d = ACK;
          wr_d    = mem_wr;
          id_d    = mem_id;
          addr_d  = mem_addr;
          wdata_d = mem_data;
        end
      end
      ACK:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Stage 0 is loaded at the end of the ACK cycle; the last stage lines up
    // with the cycle in which sram_rdata is valid.
    pipe_v_d[0]  = (state_q == ACK) && !wr_q;
    pipe_id_d[0] = id_q;
    for (int unsigned i = 1; i < RL; i++) begin
      pipe_v_d[i]  = pipe_v_q[i-1];
      pipe_id_d[i] = pipe_id_q[i-1];
    end

    if (pipe_v_q[RL-1]) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = pipe_id_q[RL-1];
      rsp_mem_d   = sram_rdata;
    end
  end

  always_ff @(posedge clkSYS) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pipe_v_q    <= '0;
      for (int unsigned i = 0; i < RL; i++) begin
        pipe_id_q[i] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_mem_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pipe_v_q    <= pipe_v_d;
      pipe_id_q   <= pipe_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_mem_q   <= rsp_mem_d;
    end
  end

  assign mem_ack    = (state_q == ACK);
  assign sram_ce    = (state_q == ACK);
  assign sram_we    = (state_q == ACK) && wr_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_mem    = rsp_mem_q;

endmodule
